// File: rtl/booth_r8_stream_encoder_pkg.sv
// rtl/booth_r8_stream_encoder_pkg.sv - shared types and sizing helpers for the radix-8 Booth stream encoder
package booth_r8_pkg;

  typedef struct packed {
    logic single;
    logic double;
    logic triple;
    logic quad;
    logic neg;
  } booth_digit_t;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic int groups_of(input int width);
    return (width + 3) / 3;
  endfunction

  function automatic int beats_of(input int width, input int lanes);
    return (groups_of(width) + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/booth_r8_stream_encoder_if.sv
// rtl/booth_r8_stream_encoder_if.sv - operand input and digit-stream output handshake bundle
interface booth_r8_stream_encoder_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  localparam int BEATS = booth_r8_pkg::beats_of(WIDTH, LANES);
  localparam int BW    = $clog2(BEATS) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mx;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_single;
  logic [LANES-1:0] out_double;
  logic [LANES-1:0] out_triple;
  logic [LANES-1:0] out_quad;
  logic [LANES-1:0] out_neg;
  logic [BW-1:0]    out_beat;
  logic             out_last;

  modport master (
    output in_valid, in_mx, in_signed, out_ready,
    input  in_ready, out_valid, out_single, out_double, out_triple,
           out_quad, out_neg, out_beat, out_last
  );

  modport slave (
    input  in_valid, in_mx, in_signed, out_ready,
    output in_ready, out_valid, out_single, out_double, out_triple,
           out_quad, out_neg, out_beat, out_last
  );
endinterface

// File: rtl/booth_r8_stream_encoder_digit_enc.sv
// rtl/booth_r8_stream_encoder_digit_enc.sv - 4-bit Booth window to one-hot magnitude plus sign
module booth_r8_digit_enc
  import booth_r8_pkg::*;
(
  input  logic [3:0]   w,
  output booth_digit_t d
);
  logic a, b, c;

  assign a = w[0] ^ w[1];
  assign b = w[1] ^ w[2];
  assign c = w[2] ^ w[3];

  // window 1111 leaves every magnitude bit clear but keeps neg set
  assign d.single = a & ~c;
  assign d.double = b & ~a;
  assign d.triple = a & c;
  assign d.quad   = c & ~a & ~b;
  assign d.neg    = w[3];
endmodule

// File: rtl/booth_r8_stream_encoder.sv
// rtl/booth_r8_stream_encoder.sv - handshaked radix-8 Booth recoder streaming LANES digit groups per beat
module booth_r8_stream_encoder
  import booth_r8_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  booth_r8_stream_encoder_if.slave s
);
  localparam int GROUPS = groups_of(WIDTH);
  localparam int BEATS  = beats_of(WIDTH, LANES);
  localparam int BW     = $clog2(BEATS) + 1;
  // extended operand plus the implicit zero below bit 0
  localparam int RW     = 3 * GROUPS + 2;
  localparam int EXTW   = RW - 1 - WIDTH;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t        state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic [RW-1:0] opnd, opnd_n, load_val;
  logic          ext, last;

  assign ext      = s.in_signed & s.in_mx[WIDTH-1];
  assign load_val = {{EXTW{ext}}, s.in_mx, 1'b0};
  assign last     = (state == EMIT) && (beat == LAST_BEAT);

  assign s.out_valid = (state == EMIT);
  assign s.out_last  = last;
  assign s.out_beat  = beat;
  assign s.in_ready  = (state == IDLE) | (last & s.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
      opnd  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      opnd  <= opnd_n;
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat;
    opnd_n  = opnd;
    case (state)
      IDLE: begin
        if (s.in_valid) begin
          state_n = EMIT;
          beat_n  = '0;
          opnd_n  = load_val;
        end
      end
      EMIT: begin
        if (s.out_ready) begin
          if (!last) begin
            beat_n = beat + BW'(1);
            opnd_n = opnd >> (3 * LANES);
          end else if (s.in_valid) begin
            beat_n = '0;
            opnd_n = load_val;
          end else begin
            state_n = IDLE;
            beat_n  = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        beat_n  = '0;
      end
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    booth_digit_t d;
    logic         pad;

    booth_r8_digit_enc u_enc (
      .w (opnd[3*k+3 -: 4]),
      .d (d)
    );

    // lanes past the last group on the final beat are forced silent
    assign pad = (32'(beat) * LANES + k) >= GROUPS;

    assign s.out_single[k] = d.single & ~pad;
    assign s.out_double[k] = d.double & ~pad;
    assign s.out_triple[k] = d.triple & ~pad;
    assign s.out_quad[k]   = d.quad   & ~pad;
    assign s.out_neg[k]    = d.neg    & ~pad;
  end
endmodule

// File: tb/tb_booth_r8_stream_encoder.sv
// tb/tb_booth_r8_stream_encoder.sv - directed and scoreboard checks of the radix-8 Booth stream encoder
module tb_booth_r8_stream_encoder;
  localparam int NOPS = 1000;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [15:0] ops [NOPS];
  bit          sg  [NOPS];

  booth_r8_stream_encoder_if #(.WIDTH(8),  .LANES(1)) i1 ();
  booth_r8_stream_encoder_if #(.WIDTH(16), .LANES(3)) i2 ();
  booth_r8_stream_encoder_if #(.WIDTH(8),  .LANES(2)) i3 ();

  booth_r8_stream_encoder #(.WIDTH(8),  .LANES(1)) u1 (.clk(clk), .rst_n(rst_n), .s(i1));
  booth_r8_stream_encoder #(.WIDTH(16), .LANES(3)) u2 (.clk(clk), .rst_n(rst_n), .s(i2));
  booth_r8_stream_encoder #(.WIDTH(8),  .LANES(2)) u3 (.clk(clk), .rst_n(rst_n), .s(i3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] enc1();
    return {i1.out_single, i1.out_double, i1.out_triple, i1.out_quad, i1.out_neg};
  endfunction

  function automatic logic [9:0] enc3();
    return {i3.out_single[1], i3.out_double[1], i3.out_triple[1], i3.out_quad[1], i3.out_neg[1],
            i3.out_single[0], i3.out_double[0], i3.out_triple[0], i3.out_quad[0], i3.out_neg[0]};
  endfunction

  task automatic exp1(input string tag, input int b, input logic l, input logic [4:0] e);
    chk({tag, ".valid"}, 64'(i1.out_valid), 64'd1);
    chk({tag, ".beat"},  64'(i1.out_beat),  64'(b));
    chk({tag, ".last"},  64'(i1.out_last),  64'(l));
    chk({tag, ".enc"},   64'(enc1()),       64'(e));
  endtask

  task automatic exp3(input string tag, input int b, input logic l, input logic [9:0] e);
    chk({tag, ".valid"}, 64'(i3.out_valid), 64'd1);
    chk({tag, ".beat"},  64'(i3.out_beat),  64'(b));
    chk({tag, ".last"},  64'(i3.out_last),  64'(l));
    chk({tag, ".enc"},   64'(enc3()),       64'(e));
  endtask

  function automatic longint dig(input logic s, input logic d, input logic t, input logic q, input logic n);
    longint m;
    m = s ? 1 : d ? 2 : t ? 3 : q ? 4 : 0;
    if (int'(s) + int'(d) + int'(t) + int'(q) > 1) m = 99;
    return n ? -m : m;
  endfunction

  initial begin
    int     sent, recv, cyc, ebeat;
    longint acc, expv;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    i1.in_valid = 0; i1.in_mx = '0; i1.in_signed = 0; i1.out_ready = 0;
    i2.in_valid = 0; i2.in_mx = '0; i2.in_signed = 0; i2.out_ready = 0;
    i3.in_valid = 0; i3.in_mx = '0; i3.in_signed = 0; i3.out_ready = 0;
    #3;
    chk("rst.valid", 64'(i1.out_valid), 64'd0);
    chk("rst.beat",  64'(i1.out_beat),  64'd0);
    chk("rst.last",  64'(i1.out_last),  64'd0);
    chk("rst.enc",   64'(enc1()),       64'd0);
    chk("rst.valid2", 64'(i2.out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 64'(i1.in_ready), 64'd1);

    // unsigned 0x07: -1, +1, 0
    i1.in_valid = 1; i1.in_mx = 8'h07; i1.in_signed = 0; i1.out_ready = 1;
    #1;
    chk("u07.accept_ready", 64'(i1.in_ready), 64'd1);
    chk("u07.pre_valid",    64'(i1.out_valid), 64'd0);
    tick(); i1.in_valid = 0; #1;
    exp1("u07.b0", 0, 0, 5'b10001);
    tick(); exp1("u07.b1", 1, 0, 5'b10000);
    tick(); exp1("u07.b2", 2, 1, 5'b00000);
    chk("u07.last_ready", 64'(i1.in_ready), 64'd1);
    tick();
    chk("u07.idle", 64'(i1.out_valid), 64'd0);

    // signed 0x80: 0, 0, -2
    i1.in_valid = 1; i1.in_mx = 8'h80; i1.in_signed = 1;
    tick(); i1.in_valid = 0; #1;
    exp1("s80.b0", 0, 0, 5'b00000);
    tick(); exp1("s80.b1", 1, 0, 5'b00000);
    tick(); exp1("s80.b2", 2, 1, 5'b01001);
    tick();

    // back-to-back: unsigned 0xFF then signed 0xFF
    i1.in_valid = 1; i1.in_mx = 8'hFF; i1.in_signed = 0;
    tick(); i1.in_mx = 8'hFF; i1.in_signed = 1; #1;
    exp1("uFF.b0", 0, 0, 5'b10001);
    chk("uFF.b0.in_ready", 64'(i1.in_ready), 64'd0);
    tick(); exp1("uFF.b1", 1, 0, 5'b00001);
    chk("uFF.b1.in_ready", 64'(i1.in_ready), 64'd0);
    tick(); exp1("uFF.b2", 2, 1, 5'b00010);
    chk("uFF.b2.in_ready", 64'(i1.in_ready), 64'd1);
    tick(); i1.in_valid = 0; #1;
    exp1("sFF.b0", 0, 0, 5'b10001);
    chk("sFF.b0.in_ready", 64'(i1.in_ready), 64'd0);
    tick(); exp1("sFF.b1", 1, 0, 5'b00001);
    tick(); exp1("sFF.b2", 2, 1, 5'b00001);
    chk("sFF.b2.in_ready", 64'(i1.in_ready), 64'd1);
    tick();
    chk("sFF.idle", 64'(i1.out_valid), 64'd0);

    // backpressure on unsigned 0xB5 (-3, -1, +3), then reset mid-stream
    i1.in_valid = 1; i1.in_mx = 8'hB5; i1.in_signed = 0; i1.out_ready = 1;
    tick(); i1.in_valid = 0; #1;
    exp1("uB5.b0", 0, 0, 5'b00101);
    tick(); i1.out_ready = 0; #1;
    exp1("uB5.b1", 1, 0, 5'b10001);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp1($sformatf("uB5.hold%0d", i), 1, 0, 5'b10001);
      chk($sformatf("uB5.hold%0d.in_ready", i), 64'(i1.in_ready), 64'd0);
    end
    rst_n = 1'b0;
    #1;
    chk("abort.valid", 64'(i1.out_valid), 64'd0);
    chk("abort.beat",  64'(i1.out_beat),  64'd0);
    chk("abort.enc",   64'(enc1()),       64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort.in_ready", 64'(i1.in_ready), 64'd1);
    chk("abort.idle",     64'(i1.out_valid), 64'd0);

    // two lanes over three groups: lane 1 of beat 1 is padding
    i3.out_ready = 1; i3.in_valid = 1; i3.in_mx = 8'hB5; i3.in_signed = 0;
    tick(); i3.in_mx = 8'hFF; i3.in_signed = 1; #1;
    exp3("l2.uB5.b0", 0, 0, 10'b10001_00101);
    tick(); exp3("l2.uB5.b1", 1, 1, 10'b00000_00100);
    chk("l2.uB5.b1.in_ready", 64'(i3.in_ready), 64'd1);
    tick(); i3.in_valid = 0; #1;
    exp3("l2.sFF.b0", 0, 0, 10'b00001_10001);
    tick(); exp3("l2.sFF.b1", 1, 1, 10'b00000_00001);
    tick();
    chk("l2.idle", 64'(i3.out_valid), 64'd0);

    // WIDTH=16, LANES=3: reconstruct every operand from its digits
    for (int i = 0; i < NOPS; i++) begin
      ops[i] = 16'($urandom);
      sg[i]  = 1'($urandom_range(0, 1));
    end
    ops[0] = 16'hFFFF; sg[0] = 1;
    ops[1] = 16'h8000; sg[1] = 1;
    ops[2] = 16'hFFFF; sg[2] = 0;
    ops[3] = 16'h0000; sg[3] = 1;
    sent = 0; recv = 0; cyc = 0; ebeat = 0; acc = 0;
    i2.out_ready = 1;
    while (recv < NOPS && cyc < 20000) begin
      i2.in_valid  = (sent < NOPS);
      i2.in_mx     = ops[(sent < NOPS) ? sent : 0];
      i2.in_signed = sg[(sent < NOPS) ? sent : 0];
      #1;
      if (i2.out_valid) begin
        chk($sformatf("rnd%0d.beat", recv), {62'(i2.out_beat), 1'b0, i2.out_last},
            {62'(ebeat), 1'b0, 1'(ebeat == 1)});
        for (int k = 0; k < 3; k++)
          acc += dig(i2.out_single[k], i2.out_double[k], i2.out_triple[k],
                     i2.out_quad[k], i2.out_neg[k]) * (longint'(1) << (3 * (ebeat * 3 + k)));
        if (i2.out_last) begin
          expv = sg[recv] ? longint'($signed(ops[recv])) : longint'({48'd0, ops[recv]});
          chk($sformatf("rnd%0d.value", recv), acc, expv);
          recv++;
          acc = 0;
          ebeat = 0;
        end else begin
          ebeat++;
        end
      end
      if (i2.in_valid && i2.in_ready) sent++;
      tick();
      cyc++;
    end
    i2.in_valid = 0;
    chk("rnd.completed", 64'(recv), 64'(NOPS));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
